// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bus shared between the requesting channels and the round-robin arbiter.
// The requesters use the master view; the arbiter uses the slave view.
interface bus_arbiter_rr_if #(
    parameter int N = 8,
    parameter int W = 8
) ();
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant;
    logic [OW-1:0]  owner;
    logic           bus_valid;
    logic [W-1:0]   data_out;
    logic           timeout;

    modport master (
        output req,
        output data,
        input  grant,
        input  owner,
        input  bus_valid,
        input  data_out,
        input  timeout
    );

    modport slave (
        input  req,
        input  data,
        output grant,
        output owner,
        output bus_valid,
        output data_out,
        output timeout
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with a contested-ownership limit: an owner that keeps requesting
// while others wait is preempted after MAX_HOLD cycles, flagged by a one-cycle timeout pulse.
module bus_arbiter_rr #(
    parameter int N        = 8,
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_rr_if.slave  bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [OW-1:0] ptr_r, ptr_nxt_s;
    logic [HW-1:0] hold_cnt_r, hold_nxt_s;
    logic [N-1:0]  grant_r, grant_nxt_s;
    logic [OW-1:0] owner_r, owner_nxt_s;
    logic          valid_r, valid_nxt_s;
    logic          timeout_r, timeout_nxt_s;

    logic [N-1:0]  mask_s;
    logic [N-1:0]  rot_s;
    logic          pick_found_s;
    int            pick_off_s;
    int            pick_idx_s;
    logic [N-1:0]  pick_grant_s;
    logic [OW-1:0] pick_owner_s;
    logic [OW-1:0] pick_ptr_s;
    logic          owner_req_s;
    logic [W-1:0]  data_out_s;

    // The current owner never competes, so the same candidate set serves release and preemption.
    assign mask_s       = bus.req & ~grant_r;
    assign rot_s        = N'({mask_s, mask_s} >> ptr_r);
    assign pick_found_s = |mask_s;
    assign owner_req_s  = |(bus.req & grant_r);

    // Round-robin pick: first candidate at or after ptr, wrapping modulo N.
    always_comb begin
        pick_off_s = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                pick_off_s = i;
            end else begin
                pick_off_s = pick_off_s;
            end
        end
        pick_idx_s = (int'(ptr_r) + pick_off_s) % N;
        for (int i = 0; i < N; i++) begin
            pick_grant_s[i] = (i == pick_idx_s);
        end
        pick_owner_s = OW'(pick_idx_s);
        pick_ptr_s   = OW'((pick_idx_s + 1) % N);
    end

    // Next-state and next-output logic for the IDLE/OWNED machine.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        hold_nxt_s    = hold_cnt_r;
        grant_nxt_s   = grant_r;
        owner_nxt_s   = owner_r;
        valid_nxt_s   = valid_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_OWNED;
                    grant_nxt_s = pick_grant_s;
                    owner_nxt_s = pick_owner_s;
                    valid_nxt_s = 1'b1;
                    ptr_nxt_s   = pick_ptr_s;
                    hold_nxt_s  = {HW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = {N{1'b0}};
                    owner_nxt_s = {OW{1'b0}};
                    valid_nxt_s = 1'b0;
                end
            end
            ST_OWNED: begin
                if (!owner_req_s || (pick_found_s && hold_cnt_r == HOLD_LAST)) begin
                    if (pick_found_s) begin
                        state_nxt_s   = ST_OWNED;
                        grant_nxt_s   = pick_grant_s;
                        owner_nxt_s   = pick_owner_s;
                        valid_nxt_s   = 1'b1;
                        ptr_nxt_s     = pick_ptr_s;
                        hold_nxt_s    = {HW{1'b0}};
                        timeout_nxt_s = owner_req_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        grant_nxt_s = {N{1'b0}};
                        owner_nxt_s = {OW{1'b0}};
                        valid_nxt_s = 1'b0;
                        hold_nxt_s  = {HW{1'b0}};
                    end
                end else if (hold_cnt_r != HOLD_LAST) begin
                    hold_nxt_s = hold_cnt_r + HW'(1);
                end else begin
                    hold_nxt_s = hold_cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = {N{1'b0}};
                owner_nxt_s = {OW{1'b0}};
                valid_nxt_s = 1'b0;
                hold_nxt_s  = {HW{1'b0}};
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {OW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            grant_r    <= {N{1'b0}};
            owner_r    <= {OW{1'b0}};
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            grant_r    <= grant_nxt_s;
            owner_r    <= owner_nxt_s;
            valid_r    <= valid_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    // Data mux driven from the registered one-hot grant; zero when nobody owns the bus.
    always_comb begin
        data_out_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (grant_r[i]) begin
                data_out_s = data_out_s | bus.data[i*W +: W];
            end else begin
                data_out_s = data_out_s;
            end
        end
    end

    assign bus.grant     = grant_r;
    assign bus.owner     = owner_r;
    assign bus.bus_valid = valid_r;
    assign bus.timeout   = timeout_r;
    assign bus.data_out  = data_out_s;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: reset, single grant, rotation, release handoff,
// hold-limit preemption, uncontested hold and asynchronous reset mid-ownership.
module tb_bus_arbiter_rr;
    localparam int N        = 8;
    localparam int W        = 8;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_miscmp = 0;

    logic [7:0] data_tab [8] = '{8'hF0, 8'h11, 8'hA5, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    bus_arbiter_rr_if #(.N(N), .W(W)) bus_if ();

    bus_arbiter_rr #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Checks every output; owner and data_out expectations come from the bench's own table.
    task automatic expect_out(input string tag, input logic [7:0] g, input int o, input logic t);
        logic       v;
        logic [7:0] d;
        v = (g != 8'h00);
        d = v ? data_tab[o] : 8'h00;
        chk_eq({tag, ".grant"}, 64'(bus_if.grant), 64'(g));
        chk_eq({tag, ".valid"}, 64'(bus_if.bus_valid), 64'(v));
        chk_eq({tag, ".timeout"}, 64'(bus_if.timeout), 64'(t));
        chk_eq({tag, ".data_out"}, 64'(bus_if.data_out), 64'(d));
        if (v) begin
            chk_eq({tag, ".owner"}, 64'(bus_if.owner), 64'(o));
        end else begin
            chk_eq({tag, ".owner"}, 64'(bus_if.owner), 64'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_out("rst", 8'h00, 0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bus_if.req = 8'h00;
        for (int i = 0; i < N; i++) begin
            bus_if.data[i*W +: W] = data_tab[i];
        end
        #12;
        expect_out("reset", 8'h00, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // single request on ch2
        bus_if.req = 8'h04;
        step();
        expect_out("s1", 8'h04, 2, 1'b0);
        bus_if.req = 8'h00;
        step();
        expect_out("s1_idle", 8'h00, 0, 1'b0);

        // full rotation, each owner holds two cycles
        do_reset();
        bus_if.req = 8'hFF;
        for (int i = 0; i < N; i++) begin
            step();
            expect_out($sformatf("s2_ch%0d_a", i), 8'(1 << i), i, 1'b0);
            step();
            expect_out($sformatf("s2_ch%0d_b", i), 8'(1 << i), i, 1'b0);
            bus_if.req[i] = 1'b0;
        end
        step();
        expect_out("s2_idle", 8'h00, 0, 1'b0);

        // release handoff: ptr is 0 here
        bus_if.req = 8'h08;
        step();
        expect_out("s3_ch3", 8'h08, 3, 1'b0);
        bus_if.req = 8'h4A;
        step();
        expect_out("s3_hold", 8'h08, 3, 1'b0);
        bus_if.req = 8'h42;
        step();
        expect_out("s3_ch6", 8'h40, 6, 1'b0);
        bus_if.req = 8'h02;
        step();
        expect_out("s3_ch1", 8'h02, 1, 1'b0);
        bus_if.req = 8'h00;
        step();
        expect_out("s3_idle", 8'h00, 0, 1'b0);

        // hold limit: ch0 owns exactly MAX_HOLD cycles, then ch1 with timeout pulse
        do_reset();
        bus_if.req = 8'h03;
        for (int c = 0; c < MAX_HOLD; c++) begin
            step();
            expect_out($sformatf("s4_hold%0d", c), 8'h01, 0, 1'b0);
        end
        step();
        expect_out("s4_preempt", 8'h02, 1, 1'b1);
        step();
        expect_out("s4_after", 8'h02, 1, 1'b0);
        bus_if.req = 8'h00;
        step();
        expect_out("s4_idle", 8'h00, 0, 1'b0);

        // uncontested owner keeps the bus; ptr is 2 here so the scan wraps to ch0
        bus_if.req = 8'h01;
        for (int c = 0; c < 40; c++) begin
            step();
            expect_out($sformatf("s5_c%0d", c), 8'h01, 0, 1'b0);
        end

        // asynchronous reset between edges while ch0 owns
        #1;
        rst = 1'b1;
        #1;
        expect_out("s6_rst", 8'h00, 0, 1'b0);
        rst = 1'b0;
        bus_if.req = 8'h30;
        step();
        expect_out("s6_ch4", 8'h10, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of requesting channels (legal range 1..32).
REQ-002 The block SHALL have parameter W, default 8, giving the data width per channel.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, giving the contested-ownership limit in cycles (legal range >=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have port req, input, N bits: per-channel bus request, level-sensitive.
REQ-007 The block SHALL have port data, input, N*W bits: channel i occupies data[i*W+W-1 : i*W].
REQ-008 The block SHALL have port grant, output, N bits: registered one-hot grant, or all-zero when no channel owns the bus.
REQ-009 The block SHALL have port owner, output, max(1,clog2(N)) bits: registered index of the granted channel.
REQ-010 The block SHALL have port bus_valid, output, 1 bit: registered; 1 exactly when grant is non-zero.
REQ-011 The block SHALL have port data_out, output, W bits: combinational slice of data selected by the registered grant; all-zero when grant is zero.
REQ-012 The block SHALL have port timeout, output, 1 bit: registered one-cycle pulse marking a forced preemption.

Function
REQ-013 The block SHALL implement two states, IDLE (grant=0) and OWNED (exactly one grant bit set).
REQ-014 The block SHALL keep a round-robin pointer ptr; arbitration picks the first channel with req=1 scanning ptr, ptr+1, ... mod N.
REQ-015 On every new grant, ptr SHALL become (new owner + 1) mod N and hold_cnt SHALL become 0.
REQ-016 IDLE: if req is non-zero at a rising edge, that edge SHALL load the arbitrated grant and enter OWNED (one-cycle latency); otherwise the block stays IDLE.
REQ-017 OWNED: hold_cnt SHALL increment by 1 per cycle while ownership continues and SHALL saturate at MAX_HOLD-1.
REQ-018 OWNED with req[owner]=0 at an edge: if any other req=1, grant SHALL pass directly to the arbitrated channel at that edge with no idle cycle; otherwise the block SHALL go IDLE.
REQ-019 OWNED with req[owner]=1, hold_cnt=MAX_HOLD-1 and any other req=1: grant SHALL pass to the arbitrated channel (owner excluded), and timeout SHALL be 1 for the following cycle only.
REQ-020 OWNED with req[owner]=1 and no other req: the owner SHALL keep the grant indefinitely, with no timeout.
REQ-021 A channel that drops req before being granted SHALL NOT be granted.
REQ-022 Requests of non-owners SHALL never alter the current grant except as defined in REQ-018 and REQ-019.
REQ-023 When N=1, preemption SHALL never occur and timeout SHALL stay 0.
REQ-024 Grant SHALL never have more than one bit set, and owner SHALL be consistent with grant whenever bus_valid=1.

Reset
REQ-025 While rst=1, grant=0, owner=0, bus_valid=0, timeout=0, data_out=0, ptr=0, hold_cnt=0 and state=IDLE, independent of clk.
REQ-026 Assertion of rst mid-ownership SHALL clear all outputs immediately; after rst deasserts, the first grant SHALL follow REQ-016 with ptr=0.

Verification
REQ-027 Scenario 1: N=8, W=8, req=8'h04, data[23:16]=8'hA5 -> after one edge: grant=8'h04, owner=2, bus_valid=1, data_out=8'hA5.
REQ-028 Scenario 2: after reset, req=8'hFF with each owner dropping its req 2 cycles after being granted -> grants visit channels 0,1,...,7 in order, with no idle cycle between owners.
REQ-029 Scenario 3: channel 3 owns and ch1 and ch6 request; ch3 releases -> ch6 granted at that edge; ch6 then releases -> ch1 granted.
REQ-030 Scenario 4: MAX_HOLD=16; ch0 holds req, ch1 requests from the start -> ch0 keeps grant exactly 16 cycles, then grant=8'h02 and timeout=1 for exactly one cycle.
REQ-031 Scenario 5: ch0 alone holds req for 40 cycles -> grant stays 8'h01 throughout and timeout stays 0.
REQ-032 Scenario 6: rst pulsed between clock edges during ownership -> grant, bus_valid and data_out read 0 before the next edge; afterwards, req=8'h30 grants ch4.
